// File: rtl/opr1_sequencer.sv
// Operate-group-1 sequencer: owns AC and L and executes one 12-bit operate word as a
// fixed chain of single-cycle steps (CLR -> CMP -> INC -> ROT). Each step drives the
// external 12-bit ALU and captures its result, or updates L locally.
// Inactive steps are skipped, so they cost zero cycles.
// Optional feature: define OPR1_BSW_EN to make instr[1] without RAR/RAL perform a
// byte swap of AC in the ROT step. Without it, that bit combination is a no-op.
module opr1_sequencer #(
  parameter int unsigned W       = 12,
  parameter logic [2:0]  OP_ADD  = 3'd0,
  parameter logic [2:0]  OP_AND  = 3'd1,
  parameter logic [2:0]  OP_CMA  = 3'd2,
  parameter logic [2:0]  OP_RAR1 = 3'd4,
  parameter logic [2:0]  OP_RAL1 = 3'd5,
  parameter logic [2:0]  OP_RAR2 = 3'd6,
  parameter logic [2:0]  OP_RAL2 = 3'd7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] instr,
  input  logic         ac_wr_en,
  input  logic [W-1:0] ac_wr_data,
  input  logic         l_wr_en,
  input  logic         l_wr_data,
  input  logic [W-1:0] alu_out,
  input  logic         alu_carry,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_cin,
  output logic [W-1:0] ac,
  output logic         link,
  output logic         busy,
  output logic         done,
  output logic         illegal
);

`ifdef OPR1_BSW_EN
  localparam bit BswEn = 1'b1;
`else
  localparam bit BswEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StCmp,
    StInc,
    StRot,
    StDone
  } state_e;

  state_e       state;
  state_e       nxt;
  logic [W-1:0] ir;
  logic [W-1:0] seq_word;
  logic         word_legal;

  // Operate group 1 only; RAR together with RAL has no defined meaning.
  function automatic logic is_legal(input logic [W-1:0] w);
    return (w[11:9] == 3'b111) && !w[8] && !(w[3] && w[2]);
  endfunction

  // First active step strictly after 'cur' for word 'w'; DONE when none remain.
  function automatic state_e step_after(input state_e cur, input logic [W-1:0] w);
    logic   clr_act, cmp_act, inc_act, rot_act;
    logic   may_clr, may_cmp, may_inc, may_rot;
    state_e res;
    clr_act = w[7] | w[6];
    cmp_act = w[5] | w[4];
    inc_act = w[0];
    rot_act = w[3] | w[2] | (BswEn & w[1]);
    may_clr = (cur == StIdle);
    may_cmp = may_clr || (cur == StClr);
    may_inc = may_cmp || (cur == StCmp);
    may_rot = may_inc || (cur == StInc);
    if (may_clr && clr_act) begin
      res = StClr;
    end else if (may_cmp && cmp_act) begin
      res = StCmp;
    end else if (may_inc && inc_act) begin
      res = StInc;
    end else if (may_rot && rot_act) begin
      res = StRot;
    end else begin
      res = StDone;
    end
    return res;
  endfunction

  // ALU operation presented while the sequencer sits in step 's'.
  function automatic logic [2:0] op_for(input state_e s, input logic [W-1:0] w);
    logic [2:0] op;
    op = OP_ADD;
    case (s)
      StClr: op = OP_AND;
      StCmp: op = OP_CMA;
      StInc: op = OP_ADD;
      StRot: begin
        if (w[3]) begin
          op = w[1] ? OP_RAR2 : OP_RAR1;
        end else if (w[2]) begin
          op = w[1] ? OP_RAL2 : OP_RAL1;
        end else begin
          op = OP_ADD;  // byte swap is done locally
        end
      end
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // Next step: in IDLE decode the incoming word, otherwise the latched one.
  always_comb begin
    seq_word   = (state == StIdle) ? instr : ir;
    word_legal = is_legal(instr);
    nxt        = step_after(state, seq_word);
  end

  // ALU operand wiring; B is only non-zero for the increment.
  always_comb begin
    alu_a   = ac;
    alu_cin = link;
    alu_b   = '0;
    if (state == StInc) begin
      alu_b = W'(1);
    end
  end

  // Sequencer FSM with registered AC/L, status pulses and ALU op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      ir      <= '0;
      ac      <= '0;
      link    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      alu_op  <= OP_ADD;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            ir   <= instr;
            busy <= 1'b1;
            if (!word_legal) begin
              state   <= StDone;
              done    <= 1'b1;
              illegal <= 1'b1;
              alu_op  <= OP_ADD;
            end else begin
              state  <= nxt;
              alu_op <= op_for(nxt, instr);
              done   <= (nxt == StDone);
            end
          end else begin
            // External writes only land while idle and not starting.
            if (ac_wr_en) begin
              ac <= ac_wr_data;
            end
            if (l_wr_en) begin
              link <= l_wr_data;
            end
          end
        end
        StClr: begin
          if (ir[7]) begin
            ac <= alu_out;
          end
          if (ir[6]) begin
            link <= 1'b0;
          end
          state  <= nxt;
          alu_op <= op_for(nxt, ir);
          done   <= (nxt == StDone);
        end
        StCmp: begin
          if (ir[5]) begin
            ac <= alu_out;
          end
          if (ir[4]) begin
            link <= ~link;
          end
          state  <= nxt;
          alu_op <= op_for(nxt, ir);
          done   <= (nxt == StDone);
        end
        StInc: begin
          ac     <= alu_out;
          link   <= link ^ alu_carry;
          state  <= nxt;
          alu_op <= op_for(nxt, ir);
          done   <= (nxt == StDone);
        end
        StRot: begin
          if (ir[3] || ir[2]) begin
            {link, ac} <= {alu_carry, alu_out};
          end else if (BswEn) begin
            ac <= {ac[5:0], ac[11:6]};
          end
          // ROT is always the last step.
          state  <= StDone;
          alu_op <= OP_ADD;
          done   <= 1'b1;
        end
        StDone: begin
          state   <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          illegal <= 1'b0;
          alu_op  <= OP_ADD;
        end
        default: begin
          state   <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          illegal <= 1'b0;
          alu_op  <= OP_ADD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opr1_sequencer.sv
// Self-checking bench for opr1_sequencer with a behavioural ALU attached.
// Expected AC/L/illegal/latency come from an instruction-level model and are queued
// when a word is started, then popped and compared when done is observed.
module tb_opr1_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] instr;
  logic        ac_wr_en;
  logic [11:0] ac_wr_data;
  logic        l_wr_en;
  logic        l_wr_data;
  logic [11:0] alu_out;
  logic        alu_carry;
  logic [2:0]  alu_op;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic        alu_cin;
  logic [11:0] ac;
  logic        link;
  logic        busy;
  logic        done;
  logic        illegal;

  always #5 clk = ~clk;

  opr1_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr      (instr),
    .ac_wr_en   (ac_wr_en),
    .ac_wr_data (ac_wr_data),
    .l_wr_en    (l_wr_en),
    .l_wr_data  (l_wr_data),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .ac         (ac),
    .link       (link),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  // Behavioural 12-bit ALU; rotates go through the link via alu_cin.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_op)
      3'd0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_out = alu_a & alu_b;
      3'd2: alu_out = ~alu_a;
      3'd4: {alu_carry, alu_out} = {alu_a[0], alu_cin, alu_a[11:1]};
      3'd5: {alu_carry, alu_out} = {alu_a[11], alu_a[10:0], alu_cin};
      3'd6: {alu_carry, alu_out} = {alu_a[1], alu_a[0], alu_cin, alu_a[11:2]};
      3'd7: {alu_carry, alu_out} = {alu_a[10], alu_a[9:0], alu_cin, alu_a[11]};
      default: ;
    endcase
  end

  typedef struct packed {
    logic [11:0] ac;
    logic        l;
    logic        ill;
    logic [7:0]  lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] cur_ac = '0;
  logic        cur_l  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  // Instruction-level reference: final AC/L and cycles from start to done.
  function automatic exp_t model(input logic [11:0] w, input logic [11:0] a, input logic l);
    exp_t        e;
    int          n;
    logic [12:0] r;
    n = 0;
    if (w[11:9] != 3'b111 || w[8] || (w[3] && w[2])) begin
      e.ac  = a;
      e.l   = l;
      e.ill = 1'b1;
      e.lat = 8'd1;
      return e;
    end
    if (w[7] || w[6]) n++;
    if (w[7]) a = '0;
    if (w[6]) l = 1'b0;
    if (w[5] || w[4]) n++;
    if (w[5]) a = ~a;
    if (w[4]) l = ~l;
    if (w[0]) begin
      n++;
      if (a == 12'o7777) l = ~l;
      a = a + 12'd1;
    end
    if (w[3] || w[2]) begin
      n++;
      r = {l, a};
      for (int i = 0; i < (w[1] ? 2 : 1); i++) begin
        r = w[3] ? {r[0], r[12:1]} : {r[11:0], r[12]};
      end
      {l, a} = r;
    end
`ifdef OPR1_BSW_EN
    else if (w[1]) begin
      n++;
      a = {a[5:0], a[11:6]};
    end
`endif
    e.ac  = a;
    e.l   = l;
    e.ill = 1'b0;
    e.lat = 8'(n + 1);
    return e;
  endfunction

  task automatic load(input logic [11:0] v, input logic lv);
    @(negedge clk);
    ac_wr_en   = 1'b1;
    ac_wr_data = v;
    l_wr_en    = 1'b1;
    l_wr_data  = lv;
    @(negedge clk);
    ac_wr_en = 1'b0;
    l_wr_en  = 1'b0;
    check("load_ac", 32'(ac), 32'(v));
    check("load_l", 32'(link), 32'(lv));
    cur_ac = v;
    cur_l  = lv;
  endtask

  // Start word w; optionally poke start/external writes at cycle extra_at, or
  // raise the external writes together with start (start must win).
  task automatic run(input logic [11:0] w, input int extra_at, input bit wr_with_start);
    exp_t e;
    int   lat;
    bit   seen;
    exp_q.push_back(model(w, cur_ac, cur_l));
    @(negedge clk);
    start = 1'b1;
    instr = w;
    if (wr_with_start) begin
      ac_wr_en   = 1'b1;
      ac_wr_data = ~cur_ac;
      l_wr_en    = 1'b1;
      l_wr_data  = ~cur_l;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    ac_wr_en = 1'b0;
    l_wr_en  = 1'b0;
    instr    = 12'($urandom);
    lat      = 0;
    seen     = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      lat = k;
      if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
      start    = 1'b0;
      ac_wr_en = 1'b0;
      l_wr_en  = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else if (k == extra_at) begin
        start      = 1'b1;
        instr      = 12'o7200;
        ac_wr_en   = 1'b1;
        ac_wr_data = 12'o5252;
        l_wr_en    = 1'b1;
        l_wr_data  = ~cur_l;
      end
    end
    start    = 1'b0;
    ac_wr_en = 1'b0;
    l_wr_en  = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    e = exp_q.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("ac", 32'(ac), 32'(e.ac));
    check("link", 32'(link), 32'(e.l));
    check("illegal", 32'(illegal), 32'(e.ill));
    cur_ac = e.ac;
    cur_l  = e.l;
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("illegal_end", 32'(illegal), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    instr      = '0;
    ac_wr_en   = 1'b0;
    ac_wr_data = '0;
    l_wr_en    = 1'b0;
    l_wr_data  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ac", 32'(ac), 32'd0);
    check("rst_link", 32'(link), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);

    load(12'o7777, 1'b0); run(12'o7200, 0, 1'b0);   // CLA
    load(12'o7777, 1'b0); run(12'o7001, 0, 1'b0);   // IAC wraps, L flips
    load(12'o0001, 1'b1); run(12'o7010, 0, 1'b0);   // RAR
    load(12'o0001, 1'b1); run(12'o7014, 0, 1'b0);   // RAR+RAL illegal
    load(12'o1234, 1'b0); run(12'o7364, 2, 1'b0);   // CLA CLL CMA CML RAL, extra start
    load(12'o1234, 1'b0); run(12'o7002, 0, 1'b0);   // BSW or no-op
    load(12'o1234, 1'b1); run(12'o7100, 0, 1'b0);   // CLL
    load(12'o1234, 1'b1); run(12'o7040, 1, 1'b0);   // CMA, writes while busy dropped
    load(12'o4321, 1'b0); run(12'o7006, 0, 1'b0);   // RTL
    load(12'o4321, 1'b1); run(12'o7012, 0, 1'b0);   // RTR
    load(12'o0055, 1'b1); run(12'o7301, 0, 1'b0);   // CLA CLL IAC
    load(12'o0707, 1'b0); run(12'o7020, 0, 1'b1);   // CML, start beats external write
    load(12'o0707, 1'b0); run(12'o7000, 0, 1'b0);   // NOP
    run(12'o6000, 0, 1'b0);
    run(12'o7400, 0, 1'b0);
    run(12'o0000, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      run({3'b111, 9'($urandom)}, 0, 1'b0);
    end

    // Reset during the CMP step aborts the word.
    load(12'o1234, 1'b1);
    @(negedge clk);
    start = 1'b1;
    instr = 12'o7040;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ac", 32'(ac), 32'd0);
    check("abort_link", 32'(link), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    cur_ac = '0;
    cur_l  = 1'b0;
    run(12'o7001, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
